// File: rtl/alu_mul_seq.sv
// Shift-and-add 8x8 unsigned multiplier sequencer that borrows the shared 8-bit ALU
// for its add and shift-right-by-1 steps; multiplier bits and carry are kept locally.
module alu_mul_seq #(
  parameter logic [3:0] ADD_CMD = 4'b0000,
  parameter logic [3:0] SHR_CMD = 4'b1010,
  parameter logic [2:0] SHR_AMT = 3'b101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [3:0]  alu_cmd,
  output logic [7:0]  alu_inA,
  output logic [7:0]  alu_inB,
  output logic        alu_sc_i,
  output logic [2:0]  alu_shift_value,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_sc_o
);

  typedef enum logic [2:0] {IDLE, ADD, SHR_HI, SHR_LO, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  a_reg;
  logic [6:0]  m_rest;
  logic [7:0]  p_hi;
  logic [7:0]  p_lo;
  logic [2:0]  cnt;
  logic        carry;
  logic        lsb;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    alu_cmd         = 4'b0000;
    alu_inA         = 8'h00;
    alu_inB         = 8'h00;
    alu_shift_value = 3'b000;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = op_b[0] ? ADD : SHR_HI;
      end
      ADD: begin
        alu_cmd   = ADD_CMD;
        alu_inA   = p_hi;
        alu_inB   = a_reg;
        state_nxt = SHR_HI;
      end
      SHR_HI: begin
        alu_cmd         = SHR_CMD;
        alu_shift_value = SHR_AMT;
        alu_inA         = p_hi;
        state_nxt       = SHR_LO;
      end
      SHR_LO: begin
        alu_cmd         = SHR_CMD;
        alu_shift_value = SHR_AMT;
        alu_inA         = p_lo;
        if (cnt == 3'd7)    state_nxt = DONE;
        else if (m_rest[0]) state_nxt = ADD;
        else                state_nxt = SHR_HI;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign alu_sc_i = 1'b0;

  // m_rest holds the multiplier bits not yet consumed; bit 0 decides the next iteration's add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg   <= 8'h00;
      m_rest  <= 7'h00;
      p_hi    <= 8'h00;
      p_lo    <= 8'h00;
      cnt     <= 3'd0;
      carry   <= 1'b0;
      lsb     <= 1'b0;
      product <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= op_a;
            m_rest <= op_b[7:1];
            p_hi   <= 8'h00;
            p_lo   <= 8'h00;
            cnt    <= 3'd0;
            carry  <= 1'b0;
            lsb    <= 1'b0;
          end
        end
        ADD: begin
          p_hi  <= alu_rslt;
          carry <= (alu_rslt < p_hi);
        end
        SHR_HI: begin
          p_hi  <= {carry, alu_rslt[6:0]};
          lsb   <= alu_sc_o;
          carry <= 1'b0;
        end
        SHR_LO: begin
          p_lo   <= {lsb, alu_rslt[6:0]};
          m_rest <= {1'b0, m_rest[6:1]};
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) product <= {p_hi, lsb, alu_rslt[6:0]};
        end
        default: begin
        end
      endcase
    end
  end

endmodule
